fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Drain-side engine for the sync FIFO (sfifo, 1-cycle registered RAM read). Pulls a commanded number of words out of the FIFO and streams them to a downstream consumer (e.g. systolic-array feeder) over a valid/ready interface.
- Marks the final word with m_last.
- Hides the FIFO read latency with a 2-entry output buffer, sustaining 1 word/cycle.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- LEN_W, 8, width of the burst-length field; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block idle; a command is accepted when cmd_valid & cmd_ready.
- cmd_len  in  LEN_W  number of words to read in the burst.
- fifo_rinc  out  1  read request to the FIFO.
- fifo_rempty  in  1  FIFO empty flag.
- fifo_rdata  in  WIDTH  FIFO read data, valid the cycle after an accepted read.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  WIDTH  output word.
- m_last  out  1  marks the final word of the burst.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: cmd_ready=1, fifo_rinc=0, m_valid=0, m_data=0, m_last=0, done=0. State=IDLE, all counters 0, buffer empty.
- Read accepted (rd_acc) = fifo_rinc & ~fifo_rempty. Only rd_acc counts as an issued read; a rinc against empty is ignored and retried.
- rd_acc at cycle N: fifo_rdata is captured into the buffer at the clk edge ending cycle N+1, so it is visible as m_data in cycle N+2 at the earliest.
- Buffer: 2-entry FIFO-ordered register pair, buf_cnt 0..2, plus an inflight bit that equals rd_acc of the previous cycle.
- Pop = m_valid & m_ready.
- fifo_rinc = (state==RUN) & (issue_rem!=0) & (buf_cnt + inflight - pop < 2). The output buffer can therefore never overflow. With m_ready held high and the FIFO non-empty, throughput is 1 word/cycle.
- fifo_rinc is combinational from state, counters and m_ready. There is no combinational path from fifo_rempty to fifo_rinc.
- m_valid = buf_cnt != 0. m_data is the head entry. m_data and m_last stay stable while m_valid & ~m_ready.
- m_last = m_valid & (deliver_rem==1).
- State IDLE: cmd_ready=1. On command accept:
  - cmd_len==0: go to DONE, with no reads and no output words.
  - otherwise: issue_rem=cmd_len, deliver_rem=cmd_len, go to RUN.
- State RUN: issue_rem decrements on each rd_acc. When the final read is accepted, go to DRAIN.
- State DRAIN: wait until deliver_rem reaches 0, then go to DONE.
- deliver_rem decrements on each pop in both RUN and DRAIN.
- State DONE: done=1 for exactly one cycle, then IDLE; cmd_ready returns to 1 in the following cycle. cmd_ready=0 in RUN, DRAIN and DONE.
- A command arriving during RUN, DRAIN or DONE is not accepted; cmd_valid must hold until cmd_ready.
- FIFO empty mid-burst: fifo_rinc stays asserted and no counter moves. Once the buffer drains, m_valid deasserts; there are no gaps inside a captured word.
- Consumer stall with a full buffer: fifo_rinc=0. A read issued in the previous cycle still lands, because inflight is counted in the issue condition.
- Simultaneous capture and pop with buf_cnt==2 cannot occur. With buf_cnt==1, capture and pop in the same cycle keeps buf_cnt=1 and shifts the new word to the head.
- Reset mid-burst: everything returns to reset values immediately. Words already read from the FIFO are lost; the upstream side is reset together with this block.
- Counters are LEN_W wide and never wrap: decrements are gated by the counter being non-zero.

Optional Feature:
- Macro FRD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits, reset 0).
  - Increments every cycle in which m_valid & ~m_ready, or state==RUN & fifo_rinc & fifo_rempty.
  - Saturates at 0xFFFF_FFFF and clears on each command accept.
- Not defined: no stall_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Preload the FIFO with 0x10..0x17, cmd_len=8, m_ready=1 -> the first m_valid appears 3 cycles after command accept. Then 8 consecutive beats 0x10..0x17, m_last on 0x17, done one cycle after that beat, exactly 8 rd_acc.
- cmd_len=0 -> done pulses in the cycle after accept; no fifo_rinc and no m_valid; cmd_ready back to 1 the cycle after.
- FIFO holds 3 words, cmd_len=6; write the remaining 3 words 10 cycles later -> 3 beats, m_valid low during the gap with fifo_rinc held high, then 3 beats with m_last on the 6th; no duplicated or dropped data.
- m_ready toggling 1,0,0,1 during an 8-word burst -> buf_cnt never exceeds 2, m_data stable during stalls, order preserved, exactly 8 FIFO reads.
- Assert rst_n low for 1 cycle mid-burst after 3 beats -> all outputs take reset values, cmd_ready=1 after reset release; a fresh cmd_len=2 burst then completes normally.
- With FRD_STALL_CNT_EN, cmd_len=4, m_ready low for 5 cycles while m_valid=1 -> stall_cnt=5 at done; a new command accept clears it to 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a commanded burst from the sync FIFO into a valid/ready stream.
// Optional stall counter enabled with FRD_STALL_CNT_EN.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             fifo_rinc,
    input  logic             fifo_rempty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done
`ifdef FRD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  issue_rem;
    logic [LEN_W-1:0]  deliver_rem;
    logic [WIDTH-1:0]  buf0;
    logic [WIDTH-1:0]  buf1;
    logic [1:0]        buf_cnt;
    logic              inflight;
    logic              pop;
    logic              rd_acc;
    logic              cmd_acc;
    logic [2:0]        occ;

    assign pop     = m_valid & m_ready;
    assign rd_acc  = fifo_rinc & ~fifo_rempty;
    assign cmd_acc = cmd_valid & cmd_ready;
    assign occ     = {1'b0, buf_cnt} + {2'b00, inflight};

    // Counting the in-flight word keeps the 2-entry buffer from overflowing.
    assign fifo_rinc = (state == S_RUN)
                     && (issue_rem != '0)
                     && (occ < 3'd2 + {2'b00, pop});

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf0;
    assign m_last  = m_valid & (deliver_rem == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            issue_rem   <= '0;
            deliver_rem <= '0;
        end else begin
            done <= 1'b0;
            if (rd_acc && issue_rem != '0)
                issue_rem <= issue_rem - LEN_W'(1);
            if (pop && deliver_rem != '0)
                deliver_rem <= deliver_rem - LEN_W'(1);
            unique case (state)
                S_IDLE: begin
                    if (cmd_acc) begin
                        cmd_ready <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            issue_rem   <= cmd_len;
                            deliver_rem <= cmd_len;
                            state       <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_acc && issue_rem == LEN_W'(1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Finish in the cycle right after the last beat pops.
                    if (deliver_rem == '0
                        || (pop && deliver_rem == LEN_W'(1))) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0     <= '0;
            buf1     <= '0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_acc;
            case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf0 <= fifo_rdata;
                    else
                        buf1 <= fifo_rdata;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cmd_acc) begin
            stall_cnt <= '0;
        end else if (((m_valid & ~m_ready)
                      | ((state == S_RUN) & fifo_rinc & fifo_rempty))
                     && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, scoreboard, random bursts.
// Stall counter checks run when FRD_STALL_CNT_EN is defined.
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             fifo_rinc;
    logic             fifo_rempty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             done;
`ifdef FRD_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .fifo_rinc(fifo_rinc),
        .fifo_rempty(fifo_rempty),
        .fifo_rdata(fifo_rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
`ifdef FRD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream sync FIFO: registered read data one cycle after accept.
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] fmem [0:255];
    int               wp;
    int               rp;
    int               rd_total = 0;

    assign fifo_rempty = (wp == rp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= 0;
            rp         <= 0;
            fifo_rdata <= '0;
        end else begin
            if (wr_en) begin
                fmem[wp % 256] <= wr_data;
                wp <= wp + 1;
            end
            if (fifo_rinc && !fifo_rempty) begin
                fifo_rdata <= fmem[rp % 256];
                rp       <= rp + 1;
                rd_total <= rd_total + 1;
            end
        end
    end

    // Consumer ready: 0 always, 1 random, 2 pattern 1,0,0,1, 3 stall x5
    int mode = 0;
    int stall_seen = 0;

    always @(posedge clk) begin
        case (mode)
            1:       m_ready <= ($urandom_range(0, 3) != 0);
            2:       m_ready <= (cyc % 4 == 0) || (cyc % 4 == 3);
            3:       m_ready <= (stall_seen >= 5);
            default: m_ready <= 1'b1;
        endcase
    end

    // Scoreboard: expected words in push order, beat count, last flag.
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_w;
    int               beats = 0;
    int               cur_len = 0;
    int               mon_acc = 0;
    int               first_v = -1;
    int               last_cyc = 0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            beats      = 0;
            cur_len    = 0;
            first_v    = -1;
            stall_prev = 1'b0;
            stall_seen = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cur_len    = int'(cmd_len);
                beats      = 0;
                mon_acc    = cyc;
                first_v    = -1;
                stall_seen = 0;
            end
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && first_v < 0)
                first_v = cyc;
            if (m_valid)
                check("last_flag", m_last, beats + 1 == cur_len);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("beat_data", m_data, exp_w);
                end
                beats++;
                last_cyc = cyc;
            end
            if (done) begin
                check("done_beats", beats, cur_len);
                check("done_lat",
                      cyc - (cur_len == 0 ? mon_acc : last_cyc), 1);
            end
            if (m_valid && !m_ready)
                stall_seen++;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic burst(input int len, input int pre, input int md,
                         input int late_at, input bit gap_chk,
                         input bit seq, input logic [WIDTH-1:0] base);
        int rem;
        int acc;
        int rd0;
        int idx;
        bit got;
        logic [WIDTH-1:0] d;
        rem  = len - pre;
        idx  = 0;
        mode = md;
        for (int i = 0; i < pre; i++) begin
            d = seq ? base + WIDTH'(idx) : WIDTH'($urandom);
            idx++;
            push(d);
        end
        rd0 = rd_total;
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        acc       = cyc;
        tick();
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (len == 0) begin
                check("len0_rinc", fifo_rinc, 0);
                check("len0_valid", m_valid, 0);
            end
            if (done) begin
                got = 1'b1;
            end else begin
                if (gap_chk && cyc >= acc + 6 && cyc <= acc + 10) begin
                    check("gap_valid", m_valid, 0);
                    check("gap_rinc", fifo_rinc, 1);
                end
                if (rem > 0 && ((late_at >= 0 && cyc >= acc + late_at)
                    || (late_at < 0 && $urandom_range(0, 2) == 0))) begin
                    d = seq ? base + WIDTH'(idx) : WIDTH'($urandom);
                    idx++;
                    wr_en   = 1'b1;
                    wr_data = d;
                    exp_q.push_back(d);
                    rem--;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
            end
        end
        wr_en = 1'b0;
        check("done_seen", got, 1);
        check("done_ready", cmd_ready, 0);
        check("rd_count", rd_total - rd0, len);
        check("leftover", exp_q.size(), 0);
        tick();
        check("done_pulse", done, 0);
        check("ready_back", cmd_ready, 1);
    endtask

    initial begin
        int k;
        int len;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rinc", fifo_rinc, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        burst(8, 8, 0, -1, 1'b0, 1'b1, 8'h10);
        check("first_valid_lat", first_v - mon_acc, 3);

        burst(0, 0, 0, -1, 1'b0, 1'b0, 8'h00);

        burst(6, 3, 0, 10, 1'b1, 1'b1, 8'h20);

        burst(8, 8, 2, -1, 1'b0, 1'b1, 8'h40);

        mode = 0;
        for (int i = 0; i < 8; i++)
            push(WIDTH'($urandom));
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(8);
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (beats < 3 && k < 100) begin
            tick();
            k++;
        end
        check("rst_wait", beats >= 3, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_rinc", fifo_rinc, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        check("post_rst_ready", cmd_ready, 1);
        tick();
        burst(2, 2, 0, -1, 1'b0, 1'b0, 8'h00);

`ifdef FRD_STALL_CNT_EN
        burst(4, 4, 3, -1, 1'b0, 1'b0, 8'h00);
        check("stall_cnt", stall_cnt, 5);
        burst(0, 0, 0, -1, 1'b0, 1'b0, 8'h00);
        check("stall_clr", stall_cnt, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(1, 20);
            burst(len, $urandom_range(0, len), 1, -1,
                  1'b0, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
